// File: rtl/branch_resolve_unit_pkg.sv
// Shared pipeline definitions for ID-stage branch resolution.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_resolve_unit_pkg;

    // Default width of the resolved/taken statistics counters.
    localparam int CNT_W_DEFAULT = 16;

    // Branch resolution FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL_1 = 2'd1,
        ST_RESOLVE = 2'd2
    } brs_state_t;

    // Hazard classes seen by a branch sitting in ID.
    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_LOAD_EX  = 2'd1,
        HZ_ALU_EX   = 2'd2,
        HZ_LOAD_MEM = 2'd3
    } hazard_t;

    // True when a producer register actually feeds one of the ID operands.
    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic [4:0] rd);
        return (rd != 5'd0) && ((rs == rd) || (rt == rd));
    endfunction

endpackage

// File: rtl/branch_resolve_unit_hazard_detect.sv
// Classifies the data hazard between the ID branch operands and EX/MEM producers.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the class is consumed by the resolve FSM in the same cycle.
module branch_hazard_detect
    import branch_resolve_unit_pkg::*;
(
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       EX_RegWrite,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rd,
    input  logic       MEM_MemRead,
    input  logic [4:0] MEM_rd,
    output hazard_t    hazard
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = reg_match(ID_rs, ID_rt, EX_rd);
    assign mem_match = reg_match(ID_rs, ID_rt, MEM_rd);

    // Priority pick: a load in EX needs the longest wait, so it dominates.
    always_comb begin
        hazard = HZ_NONE;
        if (EX_MemRead && ex_match) begin
            hazard = HZ_LOAD_EX;
        end else if (EX_RegWrite && ex_match) begin
            hazard = HZ_ALU_EX;
        end else if (MEM_MemRead && mem_match) begin
            hazard = HZ_LOAD_MEM;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves beq/bne in ID, stalling for operand hazards, and counts branch outcomes.
// Latency: resolves same cycle with no hazard, after 1 stall (ALU_EX/LOAD_MEM) or 2 (LOAD_EX).
// Backpressure: asserts Stall/BubbleEX to hold PC and IF/ID while operands are not ready.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Branch,
    input  logic             BranchNe,
    input  logic             Equal,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rd,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_rd,
    output logic             PCSrc,
    output logic             Stall,
    output logic             BubbleEX,
    output logic             Flush_IFID,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] TakenCount
);

    brs_state_t state;
    hazard_t    hazard;
    logic       branch_vld;
    logic       take;
    logic       resolve;
    logic       hold;

    branch_hazard_detect u_hazard (
        .ID_rs       (ID_rs),
        .ID_rt       (ID_rt),
        .EX_RegWrite (EX_RegWrite),
        .EX_MemRead  (EX_MemRead),
        .EX_rd       (EX_rd),
        .MEM_MemRead (MEM_MemRead),
        .MEM_rd      (MEM_rd),
        .hazard      (hazard)
    );

    assign branch_vld = Branch | BranchNe;
    assign take       = (Branch & Equal) | (BranchNe & ~Equal);

    // Decide whether this cycle stalls or resolves; reset masks everything.
    always_comb begin
        resolve = 1'b0;
        hold    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (branch_vld) begin
                    if (hazard == HZ_NONE) resolve = 1'b1;
                    else                   hold    = 1'b1;
                end
            end
            ST_STALL_1: hold = 1'b1;
            // Operands are ready by now; no hazard re-check. A vanished
            // branch resolves to nothing.
            ST_RESOLVE: resolve = branch_vld;
            default: begin
                resolve = 1'b0;
                hold    = 1'b0;
            end
        endcase
        if (!rst_n) begin
            resolve = 1'b0;
            hold    = 1'b0;
        end
    end

    assign Stall      = hold;
    assign BubbleEX   = hold;
    assign PCSrc      = resolve & take;
    assign Flush_IFID = resolve & take;

    // State sequencing: LOAD_EX waits two cycles, other hazards one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (branch_vld && (hazard == HZ_LOAD_EX)) begin
                        state <= ST_STALL_1;
                    end else if (branch_vld && (hazard != HZ_NONE)) begin
                        state <= ST_RESOLVE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_STALL_1: state <= ST_RESOLVE;
                ST_RESOLVE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Saturating outcome counters, bumped at the end of each resolve cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            BranchCount <= '0;
            TakenCount  <= '0;
        end else if (resolve) begin
            if (BranchCount != {CNT_W{1'b1}}) begin
                BranchCount <= BranchCount + CNT_W'(1);
            end
            if (take && (TakenCount != {CNT_W{1'b1}})) begin
                TakenCount <= TakenCount + CNT_W'(1);
            end
        end
    end

endmodule
